dds_seq_ctrl: RTL and testbench
===============================

Name: dds_seq_ctrl

Overview:
- Sequencer for the DDS datapath. Takes start, stop and soft-reset commands plus the phase-increment and sample-count fields from the DDS register map.
- Drives the phase accumulator and sine-LUT request, aligns LUT output with a valid pipeline, and writes samples into the output FIFO under backpressure.
- Returns busy, done and written-count status to the register map.

Parameters:
- PHASE_WIDTH, 32, phase accumulator / increment width
- SIG_WIDTH, 16, signed sample width
- CNT_WIDTH, 16, sample-count width
- LUT_LAT, 2, LUT read latency in cycles (≥1)

Ports:
- clk  in  1  clock
- a_rst_n  in  1  asynchronous reset, active-low
- i_soft_rst  in  1  synchronous soft reset (CTRL bit)
- i_start  in  1  start pulse (CTRL bit)
- i_stop  in  1  stop request (CTRL bit)
- i_phase_inc  in  PHASE_WIDTH  frequency tuning word
- i_num_samples  in  CNT_WIDTH  samples to generate
- i_fifo_afull  in  1  FIFO free space ≤ LUT_LAT
- i_lut_data  in  SIG_WIDTH  signed LUT output
- o_lut_req  out  1  LUT read strobe
- o_phase  out  PHASE_WIDTH  phase sent to LUT
- o_fifo_wr  out  1  FIFO write strobe
- o_fifo_data  out  SIG_WIDTH  FIFO write data
- o_busy  out  1  state ≠ IDLE
- o_done  out  1  sticky done status
- o_wr_count  out  CNT_WIDTH  samples written this run

Behaviour:
- Reset: a_rst_n asynchronous, active-low; clock clk. All outputs and registers are 0 and the state is IDLE. i_soft_rst has the same effect synchronously and takes priority over every other input, including an in-progress run.
- States: IDLE, LOAD, RUN, DRAIN, DONE.
- IDLE:
  - i_start → LOAD.
  - i_stop is ignored.
- LOAD (1 cycle):
  - Latch i_phase_inc and i_num_samples into shadow registers.
  - Clear the accumulator, o_wr_count and o_done.
  - If the latched count = 0 → DONE; otherwise → RUN.
- RUN: each cycle with i_fifo_afull = 0:
  - o_lut_req = 1 and o_phase = current accumulator value.
  - Accumulator += shadow increment, modulo 2^PHASE_WIDTH (wraps silently).
  - Remaining count decrements.
  - After the cycle that issues the last sample → DRAIN.
- RUN stall: when i_fifo_afull = 1, o_lut_req = 0 and the accumulator and count hold.
- RUN stop: i_stop → DRAIN the next cycle. No new requests are issued; in-flight requests still complete.
- DRAIN: no requests. Wait until the valid pipeline is empty, then → DONE.
- DONE (1 cycle): set o_done (sticky until the next LOAD or a reset), then → IDLE.
- Valid pipeline:
  - An LUT_LAT-deep shift register of o_lut_req.
  - o_fifo_wr = pipe[LUT_LAT-1].
  - o_fifo_data = i_lut_data, combinational pass-through aligned with o_fifo_wr.
  - Total latency from o_lut_req to o_fifo_wr is LUT_LAT cycles.
  - The pipeline always advances, even during stalls. i_fifo_afull slack guarantees no FIFO overflow.
- Write counter: o_wr_count increments on each o_fifo_wr and saturates at all-ones.
- o_busy = 1 in LOAD, RUN, DRAIN and DONE.
- i_start while busy is ignored. Register inputs are sampled only in LOAD; changes during a run have no effect.
- Simultaneous i_start and i_stop in IDLE: start wins. A stop on the LOAD cycle is ignored.

Optional Feature:
- Macro: DDS_CONT_MODE_EN.
- Defined: i_num_samples = 0 in LOAD enters RUN in continuous mode. Requests are issued indefinitely, the count does not decrement, and only i_stop (→ DRAIN) or a reset ends the run. o_wr_count still saturates.
- Undefined: count = 0 goes LOAD → DONE with zero writes.

Test Plan:
- Basic run: LUT_LAT=2, inc=0x4000_0000, count=4, afull=0, start → o_phase sequence 0, 0x4000_0000, 0x8000_0000, 0xC000_0000 on consecutive cycles; 4 o_fifo_wr, each 2 cycles after its request; o_done=1; o_wr_count=4; o_busy falls after DONE.
- Backpressure: count=8, afull held 1 for 3 cycles mid-run → exactly 3 request-free cycles, the accumulator holds, 8 total writes, phases contiguous.
- Stop mid-run: count=100, i_stop after the 10th request → no further requests, exactly 10 writes after drain, o_done=1, o_wr_count=10.
- Zero count: count=0 → LOAD→DONE, no o_lut_req, o_wr_count=0, o_done=1 (DDS_CONT_MODE_EN undefined). With it defined: writes continue until i_stop.
- Soft reset mid-run: i_soft_rst during RUN with 2 requests in flight → the next cycle shows IDLE, o_fifo_wr=0 with no flushed writes, and all outputs 0. A second start re-runs cleanly.
- Wrap/ignore: inc=0xFFFF_FFFF, count=3 → phases 0, 0xFFFF_FFFF, 0xFFFF_FFFE. A start pulse issued during RUN is ignored, and a new inc written during RUN does not change the phase.

Source files
------------

// File: rtl/dds_seq_ctrl.sv
// -----------------------------------------------------------------------------
// dds_seq_ctrl
//
// Sequencer for the DDS datapath. A start command latches the tuning word and
// the sample count, then steps a phase accumulator, issuing one sine-LUT read
// per cycle while the output FIFO has room. A valid pipeline of LUT_LAT stages
// lines the LUT output up with the FIFO write strobe. Busy, done and a
// written-sample count go back to the register map.
//
// Optional feature (macro DDS_CONT_MODE_EN):
//   defined   : a sample count of 0 starts a continuous run that only i_stop
//               or a reset can end.
//   undefined : a sample count of 0 completes immediately with zero writes.
//
// Parameters:
//   PHASE_WIDTH  phase accumulator / increment width
//   SIG_WIDTH    signed sample width
//   CNT_WIDTH    sample-count width
//   LUT_LAT      LUT read latency in cycles (>= 1)
//
// Ports:
//   clk            clock
//   a_rst_n        asynchronous reset, active-low
//   i_soft_rst     synchronous soft reset, overrides every other input
//   i_start        start pulse
//   i_stop         stop request (acted on only while running)
//   i_phase_inc    frequency tuning word, sampled in LOAD
//   i_num_samples  samples to generate, sampled in LOAD
//   i_fifo_afull   FIFO free space <= LUT_LAT; stalls new LUT requests
//   i_lut_data     signed LUT output, LUT_LAT cycles after o_lut_req
//   o_lut_req      LUT read strobe
//   o_phase        phase presented to the LUT
//   o_fifo_wr      FIFO write strobe
//   o_fifo_data    FIFO write data (LUT output while o_fifo_wr, else 0)
//   o_busy         sequencer not idle
//   o_done         sticky done, cleared by the next LOAD or a reset
//   o_wr_count     samples written this run, saturating
// -----------------------------------------------------------------------------
module dds_seq_ctrl #(
    parameter int PHASE_WIDTH = 32,
    parameter int SIG_WIDTH   = 16,
    parameter int CNT_WIDTH   = 16,
    parameter int LUT_LAT     = 2
) (
    input  logic                   clk,
    input  logic                   a_rst_n,
    input  logic                   i_soft_rst,
    input  logic                   i_start,
    input  logic                   i_stop,
    input  logic [PHASE_WIDTH-1:0] i_phase_inc,
    input  logic [CNT_WIDTH-1:0]   i_num_samples,
    input  logic                   i_fifo_afull,
    input  logic [SIG_WIDTH-1:0]   i_lut_data,
    output logic                   o_lut_req,
    output logic [PHASE_WIDTH-1:0] o_phase,
    output logic                   o_fifo_wr,
    output logic [SIG_WIDTH-1:0]   o_fifo_data,
    output logic                   o_busy,
    output logic                   o_done,
    output logic [CNT_WIDTH-1:0]   o_wr_count
);

`ifdef DDS_CONT_MODE_EN
    localparam bit CONT_EN = 1'b1;
`else
    localparam bit CONT_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;

    logic [PHASE_WIDTH-1:0] r_inc;
    logic [PHASE_WIDTH-1:0] r_acc;
    logic [CNT_WIDTH-1:0]   r_remain;
    logic [CNT_WIDTH-1:0]   r_wr_count;
    logic                   r_done;
    logic                   r_cont;
    logic [LUT_LAT-1:0]     r_pipe;

    logic                   w_lut_req;
    logic                   w_fifo_wr;
    logic [LUT_LAT-1:0]     w_pipe_shl;
    logic                   w_pipe_drained;

    // The top stage leaves the pipeline this cycle; if nothing sits below it,
    // the pipeline is empty from the next cycle on (DRAIN issues no requests).
    assign w_pipe_shl     = r_pipe << 1;
    assign w_pipe_drained = (w_pipe_shl == '0);

    // Soft reset also masks the write strobe so nothing in flight is flushed
    // into the FIFO on the reset cycle.
    assign w_fifo_wr = r_pipe[LUT_LAT-1] & ~i_soft_rst;

    // -------------------------------------------------------------------------
    // Next-state and request logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_lut_req    = 1'b0;

        if (i_soft_rst) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // Start wins over a simultaneous stop; stop alone is a no-op.
                    if (i_start) begin
                        w_state_next = ST_LOAD;
                    end
                end

                ST_LOAD: begin
                    // Decision uses the value being latched this cycle.
                    if ((i_num_samples == '0) && !CONT_EN) begin
                        w_state_next = ST_DONE;
                    end else begin
                        w_state_next = ST_RUN;
                    end
                end

                ST_RUN: begin
                    // A stop cycle issues no request of its own.
                    if (i_stop) begin
                        w_state_next = ST_DRAIN;
                    end else if (!i_fifo_afull) begin
                        w_lut_req = 1'b1;
                        if (!r_cont && (r_remain == CNT_WIDTH'(1))) begin
                            w_state_next = ST_DRAIN;
                        end
                    end
                end

                ST_DRAIN: begin
                    if (w_pipe_drained) begin
                        w_state_next = ST_DONE;
                    end
                end

                ST_DONE: begin
                    w_state_next = ST_IDLE;
                end

                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // State, shadow registers, accumulator, status
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            r_state    <= ST_IDLE;
            r_inc      <= '0;
            r_acc      <= '0;
            r_remain   <= '0;
            r_wr_count <= '0;
            r_done     <= 1'b0;
            r_cont     <= 1'b0;
        end else if (i_soft_rst) begin
            r_state    <= ST_IDLE;
            r_inc      <= '0;
            r_acc      <= '0;
            r_remain   <= '0;
            r_wr_count <= '0;
            r_done     <= 1'b0;
            r_cont     <= 1'b0;
        end else begin
            r_state <= w_state_next;

            if (r_state == ST_LOAD) begin
                r_inc    <= i_phase_inc;
                r_remain <= i_num_samples;
                r_cont   <= CONT_EN && (i_num_samples == '0);
                r_acc    <= '0;
            end else if (w_lut_req) begin
                // Modulo 2^PHASE_WIDTH: the carry out is simply dropped.
                r_acc <= r_acc + r_inc;
                if (!r_cont) begin
                    r_remain <= r_remain - CNT_WIDTH'(1);
                end
            end

            if (r_state == ST_LOAD) begin
                r_wr_count <= '0;
            end else if (w_fifo_wr && (r_wr_count != '1)) begin
                r_wr_count <= r_wr_count + CNT_WIDTH'(1);
            end

            // Set on entry to DONE so it is visible during the DONE cycle.
            if (w_state_next == ST_DONE) begin
                r_done <= 1'b1;
            end else if (r_state == ST_LOAD) begin
                r_done <= 1'b0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Valid pipeline: LUT_LAT-deep shift of the request strobe. It advances
    // every cycle, stalls included.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            r_pipe[0] <= 1'b0;
        end else if (i_soft_rst) begin
            r_pipe[0] <= 1'b0;
        end else begin
            r_pipe[0] <= w_lut_req;
        end
    end

    generate
        for (genvar gi = 1; gi < LUT_LAT; gi++) begin : g_pipe
            always_ff @(posedge clk or negedge a_rst_n) begin
                if (!a_rst_n) begin
                    r_pipe[gi] <= 1'b0;
                end else if (i_soft_rst) begin
                    r_pipe[gi] <= 1'b0;
                end else begin
                    r_pipe[gi] <= r_pipe[gi-1];
                end
            end
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign o_lut_req   = w_lut_req;
    assign o_phase     = r_acc;
    assign o_fifo_wr   = w_fifo_wr;
    assign o_fifo_data = w_fifo_wr ? i_lut_data : '0;
    assign o_busy      = (r_state != ST_IDLE);
    assign o_done      = r_done;
    assign o_wr_count  = r_wr_count;

endmodule

// File: tb/tb_dds_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dds_seq_ctrl
//
// Self-checking bench for dds_seq_ctrl (LUT_LAT = 2). Each run is driven cycle
// by cycle with randomized backpressure, LUT data, ignored starts and register
// writes. A transaction-level reference model predicts the request stream
// (phase k = k * inc mod 2^32), the write stream (each write exactly LUT_LAT
// cycles after its request) and the final status from the run's parameters.
// -----------------------------------------------------------------------------
module tb_dds_seq_ctrl;

    localparam int PW  = 32;
    localparam int SW  = 16;
    localparam int CW  = 16;
    localparam int LAT = 2;

    logic          clk = 1'b0;
    logic          a_rst_n;
    logic          i_soft_rst;
    logic          i_start;
    logic          i_stop;
    logic [PW-1:0] i_phase_inc;
    logic [CW-1:0] i_num_samples;
    logic          i_fifo_afull;
    logic [SW-1:0] i_lut_data;
    logic          o_lut_req;
    logic [PW-1:0] o_phase;
    logic          o_fifo_wr;
    logic [SW-1:0] o_fifo_data;
    logic          o_busy;
    logic          o_done;
    logic [CW-1:0] o_wr_count;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    dds_seq_ctrl #(
        .PHASE_WIDTH (PW),
        .SIG_WIDTH   (SW),
        .CNT_WIDTH   (CW),
        .LUT_LAT     (LAT)
    ) dut (
        .clk           (clk),
        .a_rst_n       (a_rst_n),
        .i_soft_rst    (i_soft_rst),
        .i_start       (i_start),
        .i_stop        (i_stop),
        .i_phase_inc   (i_phase_inc),
        .i_num_samples (i_num_samples),
        .i_fifo_afull  (i_fifo_afull),
        .i_lut_data    (i_lut_data),
        .o_lut_req     (o_lut_req),
        .o_phase       (o_phase),
        .o_fifo_wr     (o_fifo_wr),
        .o_fifo_data   (o_fifo_data),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_wr_count    (o_wr_count)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_lut_req"},   o_lut_req,   0);
        check_val({tag, "_phase"},     o_phase,     0);
        check_val({tag, "_fifo_wr"},   o_fifo_wr,   0);
        check_val({tag, "_fifo_data"}, o_fifo_data, 0);
        check_val({tag, "_busy"},      o_busy,      0);
        check_val({tag, "_done"},      o_done,      0);
        check_val({tag, "_wr_count"},  o_wr_count,  0);
    endtask

    // One run from an idle sequencer.
    //   stop_at : raise i_stop once this many requests have been seen (-1: never)
    //   soft_at : raise i_soft_rst once this many requests have been seen (-1: never)
    task automatic do_run(input logic [31:0] inc, input logic [15:0] cnt,
                          input int stop_at, input int soft_at, input int afull_pct);
        int          issued;
        int          written;
        int          done_pulses;
        int          exp_total;
        int          req_q[$];
        bit          run_active;
        bit          cont;
        bit          finished;
        bit          aborted;
        bit          stop_c;
        bit          soft_c;
        bit          exp_req;
        bit          exp_wr;
        logic [31:0] exp_phase;

        cont = 1'b0;
`ifdef DDS_CONT_MODE_EN
        cont = (cnt == 16'd0);
`endif
        issued      = 0;
        written     = 0;
        done_pulses = 0;
        run_active  = 1'b0;
        finished    = 1'b0;
        aborted     = 1'b0;

        for (int k = 0; k < 4000; k++) begin
            @(posedge clk);
            #1;
            // Start pulse at k=0, LOAD at k=1, first RUN cycle at k=2.
            if (k == 2) run_active = (cnt != 16'd0) || cont;

            i_start       = (k == 0) ? 1'b1 : (run_active && ($urandom_range(0, 7) == 0));
            i_phase_inc   = (k <= 1) ? inc : $urandom;
            i_num_samples = (k <= 1) ? cnt : 16'($urandom);
            i_fifo_afull  = ($urandom_range(0, 99) < afull_pct);
            i_lut_data    = 16'($urandom);
            stop_c = (k <= 1) ? ($urandom_range(0, 1) == 1)
                              : (run_active && stop_at >= 0 && issued == stop_at);
            soft_c = run_active && soft_at >= 0 && issued == soft_at;
            i_stop     = stop_c;
            i_soft_rst = soft_c;

            @(negedge clk);
            exp_req   = run_active && !i_fifo_afull && !stop_c && !soft_c;
            exp_wr    = !soft_c && (req_q.size() > 0) && (req_q[0] + LAT == k);
            exp_phase = inc * 32'(issued);

            check_val("lut_req", o_lut_req, exp_req);
            if (exp_req) check_val("phase", o_phase, exp_phase);
            check_val("fifo_wr", o_fifo_wr, exp_wr);
            if (exp_wr) check_val("fifo_data", o_fifo_data, i_lut_data);
            if (k == 0) check_val("busy_idle", o_busy, 0);
            if (k == 1 || run_active || req_q.size() > 0) check_val("busy", o_busy, 1);
            if (k >= 2) check_val("wr_count", o_wr_count, (written > 65535) ? 65535 : written);
            if (k >= 2 && run_active) check_val("done_clr", o_done, 0);
            if (k >= 2 && o_busy && o_done) done_pulses++;

            if (exp_wr) begin
                void'(req_q.pop_front());
                written++;
            end
            if (exp_req) begin
                req_q.push_back(k);
                issued++;
                if (!cont && issued == int'(cnt)) run_active = 1'b0;
            end
            if (stop_c && run_active) run_active = 1'b0;

            if (soft_c) begin
                aborted = 1'b1;
                break;
            end
            if (k >= 2 && !run_active && req_q.size() == 0 && !o_busy) begin
                finished = 1'b1;
                break;
            end
        end

        @(posedge clk);
        #1;
        i_start    = 1'b0;
        i_stop     = 1'b0;
        i_soft_rst = 1'b0;
        i_fifo_afull = 1'b0;

        if (aborted) begin
            @(negedge clk);
            check_all_zero("soft");
        end else begin
            check_val("timeout", finished, 1);
            if (stop_at >= 0 && (stop_at < int'(cnt) || cont)) exp_total = stop_at;
            else exp_total = int'(cnt);
            check_val("done_final", o_done, 1);
            check_val("done_pulse", done_pulses, 1);
            check_val("wr_final", o_wr_count, exp_total);
        end
        $display("[TB] run inc=0x%08h cnt=%0d stop_at=%0d soft_at=%0d requests=%0d writes=%0d%s",
                 inc, cnt, stop_at, soft_at, issued, written, aborted ? " (soft reset)" : "");
    endtask

    initial begin
        a_rst_n       = 1'b0;
        i_soft_rst    = 1'b0;
        i_start       = 1'b0;
        i_stop        = 1'b0;
        i_phase_inc   = '0;
        i_num_samples = '0;
        i_fifo_afull  = 1'b0;
        i_lut_data    = '0;

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        a_rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_all_zero("post_reset");

        // Basic run
        do_run(32'h4000_0000, 16'd4, -1, -1, 0);
        // Backpressure
        do_run(32'h0123_4567, 16'd8, -1, -1, 35);
        // Stop after the 10th request
        do_run($urandom, 16'd100, 10, -1, 0);
        // Zero count (continuous build ends it with a stop after 12 requests)
        do_run($urandom, 16'd0, 12, -1, 0);
        // Soft reset with requests in flight, then a clean re-run
        do_run($urandom, 16'd20, -1, 5, 0);
        do_run($urandom, 16'd6, -1, -1, 20);
        // Phase wrap
        do_run(32'hFFFF_FFFF, 16'd3, -1, -1, 0);

        // Randomized runs
        for (int r = 0; r < 20; r++) begin
            do_run($urandom,
                   16'($urandom_range(1, 40)),
                   ($urandom_range(0, 2) == 0) ? $urandom_range(0, 45) : -1,
                   ($urandom_range(0, 5) == 0) ? $urandom_range(0, 10) : -1,
                   $urandom_range(0, 50));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
